// File: rtl/tick_gen_prog.sv
// Programmable timebase: one-cycle tick every P clocks, periodic or one-shot, with tick counter.
// Optional half-period pulse on meio when TICK_GEN_MEIO_EN is defined; otherwise meio is tied to 0.
module tick_gen_prog #(
  parameter int unsigned N          = 26,
  parameter int unsigned PERIOD_RST = 50_000_000,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             mode,
  input  logic             start,
  input  logic             period_load,
  input  logic [N-1:0]     period_in,
  output logic             tick,
  output logic             meio,
  output logic             busy,
  output logic [CNT_W-1:0] tick_count,
  output logic [N-1:0]     period_q
);

  localparam logic [N-1:0] PeriodRst = N'(PERIOD_RST);
  localparam logic [N-1:0] One       = N'(1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     cnt_q, cnt_d;
  logic [N-1:0]     period_d;
  logic [N-1:0]     pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             tick_d, meio_d, busy_d;
  logic [CNT_W-1:0] tick_count_d;

  logic [N-1:0]     p_eff;
  logic [N-1:0]     last;
  logic [N-1:0]     cnt_inc;
  logic [N-1:0]     start_period;
  logic             wrap;
  logic             meio_hit;

  // A programmed period of 0 behaves as 1.
  assign p_eff   = (period_q == '0) ? One : period_q;
  assign last    = p_eff - One;
  // >= keeps the wrap safe even if the counter ever sits beyond the active period.
  assign wrap    = (cnt_q >= last);
  assign cnt_inc = cnt_q + One;

  // A load in the same cycle as start takes precedence over an older pending value.
  assign start_period = period_load ? period_in :
                        pend_vld_q  ? pend_q    : period_q;

`ifdef TICK_GEN_MEIO_EN
  logic [N-1:0] half;
  assign half     = p_eff >> 1;
  assign meio_hit = (p_eff >= N'(2)) && (cnt_inc == half);
`else
  assign meio_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    period_d     = period_q;
    pend_d       = pend_q;
    pend_vld_d   = pend_vld_q;
    tick_d       = 1'b0;
    meio_d       = 1'b0;
    tick_count_d = tick_count;

    if (period_load) begin
      pend_d     = period_in;
      pend_vld_d = 1'b1;
    end

    // start is a command and acts even while paused; it never produces a tick.
    if (start) begin
      cnt_d      = '0;
      period_d   = start_period;
      pend_vld_d = 1'b0;
      state_d    = StRun;
    end else if (enable) begin
      unique case (state_q)
        StIdle: begin
          cnt_d = '0;
          if (!mode) state_d = StRun;
        end
        StRun: begin
          if (wrap) begin
            cnt_d        = '0;
            tick_d       = 1'b1;
            tick_count_d = tick_count + CNT_W'(1);
            if (pend_vld_q) begin
              period_d   = pend_q;
              // A load landing on the wrap edge stays pending for the next wrap.
              pend_vld_d = period_load;
            end
            if (mode) state_d = StIdle;
          end else begin
            cnt_d  = cnt_inc;
            meio_d = meio_hit;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    busy_d = (state_d == StRun);
  end

  // busy mirrors the state register, except that it reads 0 in the cycle right after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= mode ? StIdle : StRun;
      cnt_q      <= '0;
      period_q   <= PeriodRst;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      tick       <= 1'b0;
      meio       <= 1'b0;
      busy       <= 1'b0;
      tick_count <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      tick       <= tick_d;
      meio       <= meio_d;
      busy       <= busy_d;
      tick_count <= tick_count_d;
    end
  end

endmodule

// File: tb/tb_tick_gen_prog.sv
// Directed bench for tick_gen_prog: periodic, reload, one-shot, pause, P=0, reset and count wrap.
// Half-period expectations follow TICK_GEN_MEIO_EN.
module tb_tick_gen_prog;

  localparam int unsigned N     = 26;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned PRST  = 50_000_000;

`ifdef TICK_GEN_MEIO_EN
  localparam bit MeioEn = 1'b1;
`else
  localparam bit MeioEn = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset, enable, mode, start, period_load;
  logic [N-1:0]     period_in;
  logic             tick, meio, busy;
  logic [CNT_W-1:0] tick_count;
  logic [N-1:0]     period_q;

  int total = 0;
  int bad   = 0;
  int exp_cnt;
  bit exp_tick;

  tick_gen_prog #(.N(N), .PERIOD_RST(PRST), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .mode        (mode),
    .start       (start),
    .period_load (period_load),
    .period_in   (period_in),
    .tick        (tick),
    .meio        (meio),
    .busy        (busy),
    .tick_count  (tick_count),
    .period_q    (period_q)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; enable = 1'b1; start = 1'b0;
    period_load = 1'b0; period_in = '0;
    step();
    chk("rst_tick", 32'(tick), 0);
    chk("rst_meio", 32'(meio), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt", 32'(tick_count), 0);
    chk("rst_period", 32'(period_q), PRST);

    // Periodic, P=5 via start+load: ticks after 5, 10, 15 edges.
    reset = 1'b0; start = 1'b1; period_load = 1'b1; period_in = 5;
    step();
    start = 1'b0; period_load = 1'b0;
    chk("t1_busy", 32'(busy), 1);
    chk("t1_period", 32'(period_q), 5);
    chk("t1_tick0", 32'(tick), 0);
    for (int k = 1; k <= 15; k++) begin
      step();
      chk("t1_tick", 32'(tick), 32'(k % 5 == 0));
      chk("t1_cnt", 32'(tick_count), 32'(k / 5));
      chk("t1_meio", 32'(meio), 32'(MeioEn && (k % 5 == 2)));
    end
    exp_cnt = 3;

    // P=8 running, load 3 while Q=2: wrap at Q=7, then every 3.
    start = 1'b1; period_load = 1'b1; period_in = 8;
    step();
    start = 1'b0; period_load = 1'b0;
    chk("t2_tick0", 32'(tick), 0);
    for (int k = 1; k <= 14; k++) begin
      period_load = (k == 3);
      period_in   = 3;
      step();
      exp_tick = (k == 8) || (k == 11) || (k == 14);
      if (exp_tick) exp_cnt++;
      chk("t2_tick", 32'(tick), 32'(exp_tick));
      chk("t2_period", 32'(period_q), (k >= 8) ? 3 : 8);
      chk("t2_cnt", 32'(tick_count), 32'(exp_cnt));
      chk("t2_meio", 32'(meio), 32'(MeioEn && (k == 4 || k == 9 || k == 12)));
    end
    period_load = 1'b0;

    // One-shot, P=4: a single tick, then idle.
    mode = 1'b1; start = 1'b1; period_load = 1'b1; period_in = 4;
    step();
    start = 1'b0; period_load = 1'b0;
    chk("t3_busy0", 32'(busy), 1);
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 4) exp_cnt++;
      chk("t3_tick", 32'(tick), 32'(k == 4));
      chk("t3_busy", 32'(busy), 32'(k < 4));
      chk("t3_cnt", 32'(tick_count), 32'(exp_cnt));
      chk("t3_meio", 32'(meio), 32'(MeioEn && (k == 2)));
    end

    // Periodic P=6, enable low for 3 cycles mid-period: tick moves from 6 to 9.
    mode = 1'b0; start = 1'b1; period_load = 1'b1; period_in = 6;
    step();
    start = 1'b0; period_load = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      enable = !(k >= 3 && k <= 5);
      step();
      if (k == 9) exp_cnt++;
      chk("t4_tick", 32'(tick), 32'(k == 9));
      chk("t4_cnt", 32'(tick_count), 32'(exp_cnt));
      chk("t4_busy", 32'(busy), 1);
      chk("t4_meio", 32'(meio), 32'(MeioEn && (k == 6)));
    end
    enable = 1'b1;

    // Load 0 then start: tick every enabled cycle.
    period_load = 1'b1; period_in = 0;
    step();
    period_load = 1'b0;
    chk("t5_load_tick", 32'(tick), 0);
    chk("t5_load_period", 32'(period_q), 6);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_start_tick", 32'(tick), 0);
    chk("t5_period", 32'(period_q), 0);
    for (int k = 1; k <= 4; k++) begin
      step();
      exp_cnt++;
      chk("t5_tick", 32'(tick), 1);
      chk("t5_cnt", 32'(tick_count), 32'(exp_cnt));
      chk("t5_meio", 32'(meio), 0);
    end

    // Reset at Q=3 of P=10, overriding start and load in the same cycle.
    start = 1'b1; period_load = 1'b1; period_in = 10;
    step();
    start = 1'b0; period_load = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("t6_tick", 32'(tick), 0);
    end
    reset = 1'b1; start = 1'b1; period_load = 1'b1; period_in = 7;
    step();
    reset = 1'b0; start = 1'b0; period_load = 1'b0;
    chk("t6_rst_tick", 32'(tick), 0);
    chk("t6_rst_meio", 32'(meio), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_cnt", 32'(tick_count), 0);
    chk("t6_rst_period", 32'(period_q), PRST);

    // P=1 for 256 cycles: tick_count wraps 255 -> 0.
    start = 1'b1; period_load = 1'b1; period_in = 1;
    step();
    start = 1'b0; period_load = 1'b0;
    chk("t7_tick0", 32'(tick), 0);
    for (int k = 1; k <= 256; k++) begin
      step();
      chk("t7_tick", 32'(tick), 1);
      chk("t7_cnt", 32'(tick_count), 32'(k % 256));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
